// File: rtl/inst_writer_pkg.sv
// Shared widths, operation enum and RV32I field constants for the instruction writer.
package inst_writer_pkg;

    localparam int unsigned OPENUM_W  = 6;
    localparam int unsigned REG_POS_W = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;

    typedef enum logic [OPENUM_W-1:0] {
        OpNop = 6'd0, OpLui, OpAuipc, OpJal, OpJalr,
        OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu,
        OpLb, OpLh, OpLw, OpLbu, OpLhu,
        OpSb, OpSh, OpSw,
        OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi,
        OpSlli, OpSrli, OpSrai,
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd
    } openum_e;

    typedef enum logic [2:0] {FmtR, FmtI, FmtSh, FmtS, FmtB, FmtU, FmtJ} fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE  = 3'd1, F3_BLT = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [2:0] F3_B    = 3'd0, F3_H    = 3'd1, F3_W   = 3'd2;
    localparam logic [2:0] F3_BU   = 3'd4, F3_HU   = 3'd5;
    localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL  = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4, F3_SR   = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

endpackage

// File: rtl/inst_writer_encoder_core.sv
// Combinational re-encoder: decoded fields back into one RV32I instruction word.
module encoder_core
    import inst_writer_pkg::*;
(
    input  logic [OPENUM_W-1:0]  openum_i,
    input  logic [REG_POS_W-1:0] rd_i,
    input  logic [REG_POS_W-1:0] rs1_i,
    input  logic [REG_POS_W-1:0] rs2_i,
    input  logic [DATA_W-1:0]    imm_i,
    output logic [DATA_W-1:0]    word_o,
    output logic                 legal_o
);

    fmt_e       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    always_comb begin
        fmt     = FmtR;
        opc     = OPC_OP;
        f3      = 3'd0;
        f7      = F7_BASE;
        legal_o = 1'b1;
        case (openum_e'(openum_i))
            OpLui:   begin fmt = FmtU; opc = OPC_LUI; end
            OpAuipc: begin fmt = FmtU; opc = OPC_AUIPC; end
            OpJal:   begin fmt = FmtJ; opc = OPC_JAL; end
            OpJalr:  begin fmt = FmtI; opc = OPC_JALR; f3 = 3'd0; end
            OpBeq:   begin fmt = FmtB; opc = OPC_BRANCH; f3 = F3_BEQ; end
            OpBne:   begin fmt = FmtB; opc = OPC_BRANCH; f3 = F3_BNE; end
            OpBlt:   begin fmt = FmtB; opc = OPC_BRANCH; f3 = F3_BLT; end
            OpBge:   begin fmt = FmtB; opc = OPC_BRANCH; f3 = F3_BGE; end
            OpBltu:  begin fmt = FmtB; opc = OPC_BRANCH; f3 = F3_BLTU; end
            OpBgeu:  begin fmt = FmtB; opc = OPC_BRANCH; f3 = F3_BGEU; end
            OpLb:    begin fmt = FmtI; opc = OPC_LOAD; f3 = F3_B; end
            OpLh:    begin fmt = FmtI; opc = OPC_LOAD; f3 = F3_H; end
            OpLw:    begin fmt = FmtI; opc = OPC_LOAD; f3 = F3_W; end
            OpLbu:   begin fmt = FmtI; opc = OPC_LOAD; f3 = F3_BU; end
            OpLhu:   begin fmt = FmtI; opc = OPC_LOAD; f3 = F3_HU; end
            OpSb:    begin fmt = FmtS; opc = OPC_STORE; f3 = F3_B; end
            OpSh:    begin fmt = FmtS; opc = OPC_STORE; f3 = F3_H; end
            OpSw:    begin fmt = FmtS; opc = OPC_STORE; f3 = F3_W; end
            OpAddi:  begin fmt = FmtI; opc = OPC_OPIMM; f3 = F3_ADD; end
            OpSlti:  begin fmt = FmtI; opc = OPC_OPIMM; f3 = F3_SLT; end
            OpSltiu: begin fmt = FmtI; opc = OPC_OPIMM; f3 = F3_SLTU; end
            OpXori:  begin fmt = FmtI; opc = OPC_OPIMM; f3 = F3_XOR; end
            OpOri:   begin fmt = FmtI; opc = OPC_OPIMM; f3 = F3_OR; end
            OpAndi:  begin fmt = FmtI; opc = OPC_OPIMM; f3 = F3_AND; end
            OpSlli:  begin fmt = FmtSh; opc = OPC_OPIMM; f3 = F3_SLL; end
            OpSrli:  begin fmt = FmtSh; opc = OPC_OPIMM; f3 = F3_SR; end
            OpSrai:  begin fmt = FmtSh; opc = OPC_OPIMM; f3 = F3_SR; f7 = F7_ALT; end
            OpAdd:   f3 = F3_ADD;
            OpSub:   begin f3 = F3_ADD; f7 = F7_ALT; end
            OpSll:   f3 = F3_SLL;
            OpSlt:   f3 = F3_SLT;
            OpSltu:  f3 = F3_SLTU;
            OpXor:   f3 = F3_XOR;
            OpSrl:   f3 = F3_SR;
            OpSra:   begin f3 = F3_SR; f7 = F7_ALT; end
            OpOr:    f3 = F3_OR;
            OpAnd:   f3 = F3_AND;
            default: legal_o = 1'b0;
        endcase
    end

    // imm[0] of B/J offsets is implicitly zero and not encoded.
    always_comb begin
        word_o = '0;
        case (fmt)
            FmtU:  word_o = {imm_i[31:12], rd_i, opc};
            FmtJ:  word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opc};
            FmtI:  word_o = {imm_i[11:0], rs1_i, f3, rd_i, opc};
            FmtSh: word_o = {f7, imm_i[4:0], rs1_i, f3, rd_i, opc};
            FmtS:  word_o = {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], opc};
            FmtB:  word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3, imm_i[4:1], imm_i[11], opc};
            default: word_o = {f7, rs2_i, rs1_i, f3, rd_i, opc};
        endcase
    end

endmodule

// File: rtl/inst_writer.sv
// Accepts decoded instruction fields, re-encodes them and writes the word byte-wise to memory.
module inst_writer
    import inst_writer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPENUM_W-1:0]  in_openum,
    input  logic [REG_POS_W-1:0] in_rd,
    input  logic [REG_POS_W-1:0] in_rs1,
    input  logic [REG_POS_W-1:0] in_rs2,
    input  logic [DATA_W-1:0]    in_imm,
    input  logic                 base_load,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic [ADDR_W-1:0]    mem_a,
    output logic [7:0]           mem_dout,
    output logic                 mem_wr,
    output logic [DATA_W-1:0]    last_inst,
    output logic                 done,
    output logic                 illegal
);

    logic [0:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] last_inst_q, last_inst_d;
    logic [DATA_W-1:0] enc_word;
    logic              enc_legal;

    encoder_core u_encoder_core (
        .openum_i (in_openum),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .imm_i    (in_imm),
        .word_o   (enc_word),
        .legal_o  (enc_legal)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        last_inst_d = last_inst_q;
        mem_wr      = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        mem_a       = '0;
        mem_dout    = '0;
        in_ready    = (state_q == ST_IDLE);
        if (state_q == ST_WRITE) begin
            mem_a    = ptr_q + {{(ADDR_W-2){1'b0}}, idx_q};
            mem_dout = 8'(last_inst_q >> {idx_q, 3'b000});
        end
        // Everything below is gated by rdy so a low rdy freezes state and suppresses strobes.
        if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (base_load) ptr_d = base_addr;
                    if (in_valid) begin
                        if (enc_legal) begin
                            last_inst_d = enc_word;
                            state_d     = ST_WRITE;
                            idx_d       = 2'd0;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    mem_wr = 1'b1;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        done    = 1'b1;
                        ptr_d   = ptr_q + 32'd4;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            ptr_q       <= '0;
            last_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            last_inst_q <= last_inst_d;
        end
    end

    assign last_inst = last_inst_q;

endmodule

// File: doc/inst_writer.md
INST_WRITER -- requirements
Module: inst_writer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: rdy  in  1  global enable; low freezes all state.
REQ-004 SHALL have: in_valid  in  1  decoded-instruction fields valid.
REQ-005 SHALL have: in_ready  out  1  block can accept fields.
REQ-006 SHALL have: in_openum  in  6  operation enum, OPENUM_TYPE.
REQ-007 SHALL have: in_rd, in_rs1, in_rs2  in  5 each  register indices, REG_POS_TYPE.
REQ-008 SHALL have: in_imm  in  32  immediate in decoded form (sign-extended, B/J byte offsets).
REQ-009 SHALL have: base_load  in  1  load write pointer from base_addr; base_addr  in  32.
REQ-010 SHALL have: mem_a  out  32  byte address; mem_dout  out  8  byte data; mem_wr  out  1  write strobe.
REQ-011 SHALL have: last_inst  out  32  last encoded word; done  out  1  word-complete pulse; illegal  out  1  rejected-enum pulse.

Function
REQ-012 SHALL re-encode fields to one RV32I word such that decoding the word reproduces openum, rd, rs1, rs2, imm for every legal input.
REQ-013 SHALL encode U-type from imm[31:12]; I-type from imm[11:0]; shifts SLLI/SRLI/SRAI from imm[4:0] with funct7 0000000, or 0100000 for SRAI.
REQ-014 SHALL encode S-type as imm[11:5], imm[4:0]; B-type as imm[12|10:5], imm[4:1|11]; J-type as imm[20|10:1|11|19:12]; imm[0] of B/J ignored.
REQ-015 SHALL encode B/S without an rd field; in_rd ignored for those; SUB/SRA use funct7 0100000.
REQ-016 SHALL have FSM states IDLE and WRITE, byte index 0..3.
REQ-017 In IDLE, in_ready SHALL be 1; rdy & in_valid & legal openum latches the word into last_inst and enters WRITE at byte 0.
REQ-018 In WRITE, each rdy cycle SHALL drive mem_wr=1, mem_a=ptr+i, mem_dout=word[8i+7:8i] (little-endian), then increment i.
REQ-019 After byte 3, SHALL pulse done for one cycle, advance ptr by 4 (mod 2^32), return to IDLE.
REQ-020 Latency: accept in cycle N, bytes in N+1..N+4, done in N+4, in_ready=1 again in N+5.
REQ-021 in_ready SHALL be 0 throughout WRITE; in_valid there is ignored.
REQ-022 NOP or undefined openum accepted in IDLE SHALL pulse illegal for one cycle, write nothing, leave ptr and last_inst unchanged, stay IDLE.
REQ-023 base_load SHALL take effect only in IDLE; with simultaneous accept, the word SHALL be written at the new base.
REQ-024 rdy=0 SHALL hold state, byte index, ptr; mem_wr, done, illegal SHALL be 0 that cycle.

Reset
REQ-025 rst SHALL force IDLE, ptr=0, i=0, last_inst=0, mem_a=0, mem_dout=0, mem_wr=0, done=0, illegal=0, in_ready=1 next edge.
REQ-026 rst mid-WRITE SHALL abort with no further byte writes; partial word is not completed.

Structure
REQ-027 OPENUM, opcode, funct3, funct7 constants and the OPENUM/REG_POS/DATA/ADDR widths SHALL live in the shared defines file.
REQ-028 Field-to-word encoding SHALL be a combinational sub-module encoder_core; the FSM and byte serializer stay in inst_writer.

Verification
REQ-029 base 0x100, ADDI rd=1 rs1=2 imm=0xFFFFFFFF -> last_inst 0xFFF10093; bytes 93,00,F1,FF at 0x100..0x103; done at N+4.
REQ-030 SW rs1=2 rs2=5 imm=8 -> 0x00512423; BEQ rs1=0 rs2=0 imm=0xFFFFFFFC -> 0xFE000EE3.
REQ-031 SRAI rd=3 rs1=3 imm=5 -> 0x4051D193; JAL rd=1 imm=0x800 -> 0x001000EF; pointer advances 4 per word.
REQ-032 openum=NOP with in_valid -> illegal=1 one cycle, mem_wr never 1, in_ready stays 1.
REQ-033 rdy low 3 cycles at byte 2 -> mem_wr=0 those cycles; byte 2 then written at same address; done delayed 3 cycles.
REQ-034 rst at byte 1 -> no further mem_wr, in_ready=1 and mem_a=0 next cycle; next word written from address 0.
